pal_macrocell_bank: RTL and testbench

- Output macrocell stage directly downstream of the PAL AND/OR array.
- Consumes the OR-plane sum terms. Per output, selects combinational or registered (D flip-flop) mode, output polarity and output enable.
- Returns a feedback term to the AND plane.
- Macrocell configuration is loaded through a small serial shift interface with an atomic commit, so live outputs never see a partially loaded configuration.

---
 rtl/pal_pkg.sv | 22 ++
 rtl/pal_macrocell.sv | 39 +++
 rtl/pal_macrocell_bank.sv | 140 ++++++++++++++
 tb/tb_pal_macrocell_bank.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// Shared types and constants for the PAL output macrocell bank.
package pal_pkg;

   localparam int CFG_BITS_PER_MC = 3;
   localparam int MC_REG_BIT      = 0;
   localparam int MC_INV_BIT      = 1;
   localparam int MC_OE_BIT       = 2;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } cfg_state_e;

   // Packed so that bit order matches the serial stream: {oe, invert, reg_mode}.
   typedef struct packed {
      logic oe;
      logic invert;
      logic reg_mode;
   } mc_cfg_t;

endpackage

// File: rtl/pal_macrocell.sv
// One PAL output macrocell: D flip-flop with clock enable, comb/reg mode mux,
// output polarity and output enable.
module pal_macrocell
   import pal_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    ce,
   input  logic    or_term_i,
   input  mc_cfg_t cfg_i,
   output logic    pin_out_o,
   output logic    pin_oe_o,
   output logic    fb_o
);

   logic q_q;
   logic q_d;
   logic mode_val;

   // q tracks the sum term in every mode so a later switch to registered
   // mode exposes the most recent captured value.
   always_comb begin
      q_d = ce ? or_term_i : q_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign mode_val  = cfg_i.reg_mode ? q_q : or_term_i;
   assign pin_out_o = mode_val ^ cfg_i.invert;
   assign pin_oe_o  = cfg_i.oe;
   assign fb_o      = mode_val;

endmodule

// File: rtl/pal_macrocell_bank.sv
// Bank of PAL output macrocells with a serial config loader and atomic commit.
// Optional build macro PAL_MC_CFG_PARITY_EN adds a trailing even-parity bit and cfg_err.
module pal_macrocell_bank
   import pal_pkg::*;
#(
   parameter int N_OUT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [N_OUT-1:0] or_terms,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic [N_OUT-1:0] pin_out,
   output logic [N_OUT-1:0] pin_oe,
   output logic [N_OUT-1:0] fb
`ifdef PAL_MC_CFG_PARITY_EN
   ,
   output logic             cfg_err
`endif
);

   localparam int CFG_W = N_OUT * CFG_BITS_PER_MC;
`ifdef PAL_MC_CFG_PARITY_EN
   localparam int STREAM_LEN = CFG_W + 1;
`else
   localparam int STREAM_LEN = CFG_W;
`endif
   localparam int CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(STREAM_LEN - 1);
   localparam logic [CNT_W-1:0] CFG_W_CNT = CNT_W'(CFG_W);

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CFG_W-1:0] active_q, active_d;
`ifdef PAL_MC_CFG_PARITY_EN
   logic             err_q, err_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
`ifdef PAL_MC_CFG_PARITY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
`ifdef PAL_MC_CFG_PARITY_EN
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      cfg_ready = 1'b0;
      cfg_done  = 1'b0;
`ifdef PAL_MC_CFG_PARITY_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = SHIFT;
               count_d = '0;
            end
         end
         SHIFT: begin
            cfg_ready = 1'b1;
            // A restart wins over any bit presented in the same cycle.
            if (cfg_start) begin
               count_d = '0;
            end else if (cfg_valid) begin
               if (count_q < CFG_W_CNT) begin
                  shadow_d[count_q] = cfg_bit;
               end
               if (count_q == LAST_IDX) begin
`ifdef PAL_MC_CFG_PARITY_EN
                  if (cfg_bit == ^shadow_q) begin
                     state_d = COMMIT;
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
`else
                  state_d = COMMIT;
`endif
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         COMMIT: begin
            cfg_done = 1'b1;
            active_d = shadow_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef PAL_MC_CFG_PARITY_EN
   assign cfg_err = err_q;
`endif

   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cell
      mc_cfg_t cell_cfg;

      assign cell_cfg.reg_mode = active_q[gi*CFG_BITS_PER_MC + MC_REG_BIT];
      assign cell_cfg.invert   = active_q[gi*CFG_BITS_PER_MC + MC_INV_BIT];
      assign cell_cfg.oe       = active_q[gi*CFG_BITS_PER_MC + MC_OE_BIT];

      pal_macrocell u_cell (
         .clk       (clk),
         .rst       (rst),
         .ce        (ce),
         .or_term_i (or_terms[gi]),
         .cfg_i     (cell_cfg),
         .pin_out_o (pin_out[gi]),
         .pin_oe_o  (pin_oe[gi]),
         .fb_o      (fb[gi])
      );
   end

endmodule

// File: tb/tb_pal_macrocell_bank.sv
// Randomized self-checking bench for pal_macrocell_bank against a behavioural model.
// Build with PAL_MC_CFG_PARITY_EN defined to exercise the parity/cfg_err path.
module tb_pal_macrocell_bank;

   localparam int N = 2;
   localparam int W = 6;
`ifdef PAL_MC_CFG_PARITY_EN
   localparam int SL = W + 1;
`else
   localparam int SL = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ce = 1'b0;
   logic         cfg_start = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_bit = 1'b0;
   logic [N-1:0] or_terms = '0;
   logic         cfg_ready, cfg_done;
   logic [N-1:0] pin_out, pin_oe, fb;
`ifdef PAL_MC_CFG_PARITY_EN
   logic         cfg_err;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   // Model: captured flop values and the committed per-cell configuration.
   logic [N-1:0] m_q = '0, m_reg = '0, m_inv = '0, m_oe = '0;

   pal_macrocell_bank #(.N_OUT(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .or_terms  (or_terms),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .pin_out   (pin_out),
      .pin_oe    (pin_oe),
      .fb        (fb)
`ifdef PAL_MC_CFG_PARITY_EN
      ,
      .cfg_err   (cfg_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_fb();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_reg[i] ? m_q[i] : or_terms[i];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_pin();
      return exp_fb() ^ m_inv;
   endfunction

   function automatic logic [SL-1:0] mk_stream(input logic [W-1:0] d);
`ifdef PAL_MC_CFG_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   task automatic apply_cfg(input logic [W-1:0] b);
      for (int i = 0; i < N; i++) begin
         m_reg[i] = b[3*i];
         m_inv[i] = b[3*i+1];
         m_oe[i]  = b[3*i+2];
      end
   endtask

   // Advance one clock and update the model with the inputs present at the edge.
   task automatic step();
      logic [N-1:0] t;
      logic c, r;
      t = or_terms; c = ce; r = rst;
      @(posedge clk);
      #1;
      if (r) begin
         m_q = '0; m_reg = '0; m_inv = '0; m_oe = '0;
      end else if (c) begin
         m_q = t;
      end
   endtask

   task automatic load(input logic [SL-1:0] s, input bit rand_dp, input bit in_shift,
                       input bit expect_commit, input int gap_pct, input string tag);
      int acc;
      int guard;
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = ~s[0];
      #1;
      total_cnt++;
      if (cfg_ready !== in_shift)
         $display("FAIL %s start_ready got %b want %b", tag, cfg_ready, in_shift);
      else pass_cnt++;
      step();
      cfg_start = 1'b0;
      acc = 0;
      guard = 0;
      while (acc < SL && guard < 500) begin
         guard++;
         if (rand_dp) begin
            or_terms = N'($urandom);
            ce = 1'($urandom);
         end
         cfg_valid = ($urandom_range(0, 99) >= gap_pct);
         cfg_bit   = s[acc];
         #1;
         total_cnt++;
         if ({cfg_ready, cfg_done, pin_out, pin_oe, fb} !== {2'b10, exp_pin(), m_oe, exp_fb()})
            $display("FAIL %s shift acc=%0d rdy/done/pin/oe/fb got %b want %b", tag, acc,
                     {cfg_ready, cfg_done, pin_out, pin_oe, fb}, {2'b10, exp_pin(), m_oe, exp_fb()});
         else pass_cnt++;
         if (cfg_valid) acc++;
         step();
      end
      cfg_valid = 1'b0;
      #1;
      total_cnt++;
      if ({cfg_ready, cfg_done, pin_out, pin_oe, fb} !== {1'b0, expect_commit, exp_pin(), m_oe, exp_fb()})
         $display("FAIL %s commit rdy/done/pin/oe/fb got %b want %b", tag,
                  {cfg_ready, cfg_done, pin_out, pin_oe, fb}, {1'b0, expect_commit, exp_pin(), m_oe, exp_fb()});
      else pass_cnt++;
`ifdef PAL_MC_CFG_PARITY_EN
      total_cnt++;
      if (cfg_err !== !expect_commit)
         $display("FAIL %s cfg_err got %b want %b", tag, cfg_err, !expect_commit);
      else pass_cnt++;
`endif
      step();
      if (expect_commit) apply_cfg(s[W-1:0]);
      #1;
      total_cnt++;
      if ({cfg_ready, cfg_done, pin_out, pin_oe, fb} !== {2'b00, exp_pin(), m_oe, exp_fb()})
         $display("FAIL %s after rdy/done/pin/oe/fb got %b want %b", tag,
                  {cfg_ready, cfg_done, pin_out, pin_oe, fb}, {2'b00, exp_pin(), m_oe, exp_fb()});
      else pass_cnt++;
`ifdef PAL_MC_CFG_PARITY_EN
      total_cnt++;
      if (cfg_err !== 1'b0) $display("FAIL %s cfg_err_clear got %b want 0", tag, cfg_err);
      else pass_cnt++;
`endif
      $display("load %s stream=%b commit=%0b", tag, s, expect_commit);
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; or_terms = 2'b01;
      step();
      step();
      #1;
      total_cnt++;
      if ({pin_out, fb, pin_oe, cfg_ready, cfg_done} !== {2'b01, 2'b01, 2'b00, 1'b0, 1'b0})
         $display("FAIL reset pin/fb/oe/rdy/done got %b want %b",
                  {pin_out, fb, pin_oe, cfg_ready, cfg_done}, 8'b01010000);
      else pass_cnt++;
`ifdef PAL_MC_CFG_PARITY_EN
      total_cnt++;
      if (cfg_err !== 1'b0) $display("FAIL reset cfg_err got %b want 0", cfg_err);
      else pass_cnt++;
`endif
      rst = 1'b0;
      $display("reset done");
   endtask

   task automatic test_load_plan();
      or_terms = 2'b01; ce = 1'b1;
      load(mk_stream(6'b111011), 1'b0, 1'b0, 1'b1, 0, "plan");
      or_terms = 2'b10;
      #1;
      total_cnt++;
      if ({pin_out, fb, pin_oe} !== {2'b10, 2'b01, 2'b10})
         $display("FAIL plan_pre pin/fb/oe got %b want %b", {pin_out, fb, pin_oe}, 6'b100110);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({pin_out, fb, pin_oe} !== {2'b01, 2'b10, 2'b10})
         $display("FAIL plan_post pin/fb/oe got %b want %b", {pin_out, fb, pin_oe}, 6'b011010);
      else pass_cnt++;
   endtask

   task automatic test_ce_hold();
      logic [N-1:0] hp, hf;
      ce = 1'b0;
      hp = exp_pin();
      hf = exp_fb();
      for (int k = 0; k < 3; k++) begin
         or_terms = ~or_terms;
         #1;
         total_cnt++;
         if ({pin_out, fb} !== {hp, hf})
            $display("FAIL ce_hold k=%0d pin/fb got %b want %b", k, {pin_out, fb}, {hp, hf});
         else pass_cnt++;
         step();
      end
      ce = 1'b1; or_terms = 2'b11;
      #1;
      total_cnt++;
      if ({pin_out, fb} !== {hp, hf})
         $display("FAIL ce_latency pin/fb got %b want %b", {pin_out, fb}, {hp, hf});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({pin_out, fb} !== {2'b00, 2'b11})
         $display("FAIL ce_update pin/fb got %b want %b", {pin_out, fb}, 4'b0011);
      else pass_cnt++;
      $display("ce hold checked");
   endtask

   task automatic test_abort();
      logic [W-1:0] nv;
      nv = 6'b010100;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cfg_valid = 1'b1;
         cfg_bit = ~nv[k];
         step();
      end
      load(mk_stream(nv), 1'b1, 1'b1, 1'b1, 0, "restart");
   endtask

   task automatic test_reset_midload();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cfg_valid = 1'b1;
         cfg_bit = 1'($urandom);
         step();
      end
      cfg_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      total_cnt++;
      if ({cfg_ready, cfg_done, pin_oe, pin_out, fb} !== {2'b00, 2'b00, or_terms, or_terms})
         $display("FAIL midload_rst rdy/done/oe/pin/fb got %b want %b",
                  {cfg_ready, cfg_done, pin_oe, pin_out, fb}, {2'b00, 2'b00, or_terms, or_terms});
      else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         cfg_valid = 1'($urandom);
         cfg_bit = 1'($urandom);
         or_terms = N'($urandom);
         #1;
         total_cnt++;
         if ({cfg_ready, cfg_done, pin_out, pin_oe, fb} !== {2'b00, exp_pin(), m_oe, exp_fb()})
            $display("FAIL midload_idle k=%0d got %b want %b", k,
                     {cfg_ready, cfg_done, pin_out, pin_oe, fb}, {2'b00, exp_pin(), m_oe, exp_fb()});
         else pass_cnt++;
         step();
      end
      cfg_valid = 1'b0;
      $display("reset mid-load checked");
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 3; k++) begin
            cfg_valid = 1'($urandom);
            cfg_bit = 1'($urandom);
            or_terms = N'($urandom);
            ce = 1'($urandom);
            #1;
            total_cnt++;
            if ({cfg_ready, cfg_done, pin_out, pin_oe, fb} !== {2'b00, exp_pin(), m_oe, exp_fb()})
               $display("FAIL rand_idle it=%0d got %b want %b", it,
                        {cfg_ready, cfg_done, pin_out, pin_oe, fb}, {2'b00, exp_pin(), m_oe, exp_fb()});
            else pass_cnt++;
            step();
         end
         load(mk_stream(W'($urandom)), 1'b1, 1'b0, 1'b1, 30, "rand");
      end
   endtask

   task automatic test_parity();
`ifdef PAL_MC_CFG_PARITY_EN
      logic [SL-1:0] s;
      load(mk_stream(6'b101101), 1'b1, 1'b0, 1'b1, 20, "par_good");
      s = mk_stream(6'b010011);
      s[SL-1] = ~s[SL-1];
      load(s, 1'b1, 1'b0, 1'b0, 20, "par_bad");
`endif
   endtask

   initial begin
      test_reset();
      test_load_plan();
      test_ce_hold();
      test_abort();
      test_reset_midload();
      test_random();
      test_parity();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
